// File: rtl/stage_id_pipe_pkg.sv
// rtl/stage_id_pipe_pkg.sv - operand selects, control-vector layout, decoder and immediate helpers
package stage_id_pipe_pkg;

  localparam int CTRL_W = 11;

  localparam int CTRL_IS_OP       = 0;
  localparam int CTRL_IS_LUI      = 1;
  localparam int CTRL_IS_AUIPC    = 2;
  localparam int CTRL_IS_JAL      = 3;
  localparam int CTRL_IS_JALR     = 4;
  localparam int CTRL_IS_BRANCH   = 5;
  localparam int CTRL_IS_LD_MEM   = 6;
  localparam int CTRL_IS_ST_MEM   = 7;
  localparam int CTRL_IS_MISC_MEM = 8;
  localparam int CTRL_IS_SYSTEM   = 9;
  localparam int CTRL_ILLEGAL     = 10;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    SEL_REG  = 2'b00,
    SEL_IMM  = 2'b01,
    SEL_PC   = 2'b10,
    SEL_ZERO = 2'b11
  } sel_e;

  typedef struct packed {
    sel_e              sel_a;
    sel_e              sel_b;
    logic [3:0]        alu_op;
    logic [CTRL_W-1:0] ctrl;
  } dec_t;

  // Main decoder: control vector, operand selects and ALU op for RV32I
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.sel_a  = SEL_ZERO;
    d.sel_b  = SEL_ZERO;
    d.alu_op = 4'd0;
    d.ctrl   = '0;
    case (instr[6:0])
      OPC_OP: begin
        d.ctrl[CTRL_IS_OP] = 1'b1;
        d.sel_a  = SEL_REG;
        d.sel_b  = SEL_REG;
        d.alu_op = {instr[30], instr[14:12]};
      end
      OPC_OP_IMM: begin
        d.ctrl[CTRL_IS_OP] = 1'b1;
        d.sel_a  = SEL_REG;
        d.sel_b  = SEL_IMM;
        d.alu_op = {(instr[14:12] == 3'b101) & instr[30], instr[14:12]};
      end
      OPC_LUI:      begin d.ctrl[CTRL_IS_LUI] = 1'b1; d.sel_b = SEL_IMM; end
      OPC_AUIPC:    begin d.ctrl[CTRL_IS_AUIPC] = 1'b1; d.sel_a = SEL_PC; d.sel_b = SEL_IMM; end
      OPC_JAL:      begin d.ctrl[CTRL_IS_JAL] = 1'b1; d.sel_a = SEL_PC; d.sel_b = SEL_IMM; end
      OPC_JALR:     begin d.ctrl[CTRL_IS_JALR] = 1'b1; d.sel_a = SEL_REG; d.sel_b = SEL_IMM; end
      OPC_BRANCH:   begin d.ctrl[CTRL_IS_BRANCH] = 1'b1; d.sel_a = SEL_REG; d.sel_b = SEL_REG; end
      OPC_LOAD:     begin d.ctrl[CTRL_IS_LD_MEM] = 1'b1; d.sel_a = SEL_REG; d.sel_b = SEL_IMM; end
      OPC_STORE:    begin d.ctrl[CTRL_IS_ST_MEM] = 1'b1; d.sel_a = SEL_REG; d.sel_b = SEL_IMM; end
      OPC_MISC_MEM: d.ctrl[CTRL_IS_MISC_MEM] = 1'b1;
      OPC_SYSTEM:   begin d.ctrl[CTRL_IS_SYSTEM] = 1'b1; d.sel_a = SEL_REG; end
      default:      d.ctrl[CTRL_ILLEGAL] = 1'b1;
    endcase
    return d;
  endfunction

  // Immediate generator; result is the 32-bit sign-extended immediate
  function automatic logic [31:0] gen_imm(input logic [31:0] i);
    case (i[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:
        return {{20{i[31]}}, i[31:20]};
      OPC_STORE:
        return {{20{i[31]}}, i[31:25], i[11:7]};
      OPC_BRANCH:
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        return {i[31:12], 12'd0};
      OPC_JAL:
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:
        return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/stage_id_pipe_if.sv
// rtl/stage_id_pipe_if.sv - decode-stage signal bundle; perf outputs exist only with STAGE_ID_PERF_EN
interface stage_id_pipe_if #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3
);
  import stage_id_pipe_pkg::*;

  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [31:0]               instruction_i;
  logic [XLEN-1:0]           pc_i;
  logic [4:0]                rd_i;
  logic [XLEN-1:0]           rf_wd_i;
  logic                      rf_we_i;
  logic [NUM_FWD-1:0]        fwd_valid_i;
  logic [5*NUM_FWD-1:0]      fwd_rd_i;
  logic [XLEN*NUM_FWD-1:0]   fwd_dat_i;
  logic                      ex_is_load_i;
  logic                      flush_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [XLEN-1:0]           out_pc_o;
  logic [2:0]                out_funct3_o;
  logic [4:0]                out_rd_o;
  logic [3:0]                out_alu_op_o;
  logic [11:0]               out_csr_addr_o;
  logic [XLEN-1:0]           out_dat_a_o;
  logic [XLEN-1:0]           out_dat_b_o;
  logic [XLEN-1:0]           out_rs2_dat_o;
  logic [XLEN-1:0]           out_imm_o;
  logic [CTRL_W-1:0]         out_ctrl_o;
`ifdef STAGE_ID_PERF_EN
  logic [31:0]               perf_stall_o;
  logic [31:0]               perf_flush_o;
`endif

  modport master (
`ifdef STAGE_ID_PERF_EN
    input  perf_stall_o, perf_flush_o,
`endif
    output in_valid_i, instruction_i, pc_i, rd_i, rf_wd_i, rf_we_i,
           fwd_valid_i, fwd_rd_i, fwd_dat_i, ex_is_load_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_funct3_o, out_rd_o, out_alu_op_o,
           out_csr_addr_o, out_dat_a_o, out_dat_b_o, out_rs2_dat_o, out_imm_o, out_ctrl_o
  );

  modport slave (
`ifdef STAGE_ID_PERF_EN
    output perf_stall_o, perf_flush_o,
`endif
    input  in_valid_i, instruction_i, pc_i, rd_i, rf_wd_i, rf_we_i,
           fwd_valid_i, fwd_rd_i, fwd_dat_i, ex_is_load_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_funct3_o, out_rd_o, out_alu_op_o,
           out_csr_addr_o, out_dat_a_o, out_dat_b_o, out_rs2_dat_o, out_imm_o, out_ctrl_o
  );
endinterface

// File: rtl/stage_id_pipe_fwd_sel.sv
// rtl/stage_id_pipe_fwd_sel.sv - fwd_sel: prioritised forwarding plus write-through for one source register
module fwd_sel
  import stage_id_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3
) (
  input  logic [4:0]              rs_i,
  input  logic [XLEN-1:0]         rf_rdata_i,
  input  logic [NUM_FWD-1:0]      fwd_valid_i,
  input  logic [5*NUM_FWD-1:0]    fwd_rd_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_dat_i,
  input  logic                    rf_we_i,
  input  logic [4:0]              rd_i,
  input  logic [XLEN-1:0]         rf_wd_i,
  output logic [XLEN-1:0]         dat_o
);

  // Lowest priority first so later assignments override: RF, write-through, channels high..low, x0
  always_comb begin
    dat_o = rf_rdata_i;
    if (rf_we_i && (rd_i == rs_i)) dat_o = rf_wd_i;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_valid_i[k] && (fwd_rd_i[5*k +: 5] == rs_i)) dat_o = fwd_dat_i[XLEN*k +: XLEN];
    end
    if (rs_i == 5'd0) dat_o = '0;
  end

endmodule

// File: rtl/stage_id_pipe.sv
// rtl/stage_id_pipe.sv - RV32 decode stage with forwarding, load-use stall and ID/EX register; STAGE_ID_PERF_EN adds stall/flush counters
module stage_id_pipe
  import stage_id_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  stage_id_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic [3:0]        alu_op;
    logic [11:0]       csr;
    logic [XLEN-1:0]   dat_a;
    logic [XLEN-1:0]   dat_b;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  logic [XLEN-1:0] rf_q [32];
  logic [4:0]      rs1, rs2;
  dec_t            dec;
  logic [XLEN-1:0] imm, rs1_dat, rs2_dat, dat_a, dat_b;
  logic            rs1_used, rs2_used, hazard, adv;
  id_ex_t          id_ex_q, id_ex_d, id_ex_new;
  logic            valid_q, valid_d;

  assign rs1 = bus.instruction_i[19:15];
  assign rs2 = bus.instruction_i[24:20];
  assign dec = decode(bus.instruction_i);
  assign imm = XLEN'($signed(gen_imm(bus.instruction_i)));

  // Register file write port; contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    if (bus.rf_we_i && (bus.rd_i != 5'd0)) rf_q[bus.rd_i] <= bus.rf_wd_i;
  end

  fwd_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .rs_i(rs1), .rf_rdata_i(rf_q[rs1]), .fwd_valid_i(bus.fwd_valid_i), .fwd_rd_i(bus.fwd_rd_i),
    .fwd_dat_i(bus.fwd_dat_i), .rf_we_i(bus.rf_we_i), .rd_i(bus.rd_i), .rf_wd_i(bus.rf_wd_i),
    .dat_o(rs1_dat)
  );

  fwd_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .rs_i(rs2), .rf_rdata_i(rf_q[rs2]), .fwd_valid_i(bus.fwd_valid_i), .fwd_rd_i(bus.fwd_rd_i),
    .fwd_dat_i(bus.fwd_dat_i), .rf_we_i(bus.rf_we_i), .rd_i(bus.rd_i), .rf_wd_i(bus.rf_wd_i),
    .dat_o(rs2_dat)
  );

  // ALU operand muxes
  always_comb begin
    case (dec.sel_a)
      SEL_REG: dat_a = rs1_dat;
      SEL_IMM: dat_a = imm;
      SEL_PC:  dat_a = bus.pc_i;
      default: dat_a = '0;
    endcase
    case (dec.sel_b)
      SEL_REG: dat_b = rs2_dat;
      SEL_IMM: dat_b = imm;
      SEL_PC:  dat_b = bus.pc_i;
      default: dat_b = '0;
    endcase
  end

  // Load-use hazard: the EX load's data is not ready for a source we actually read
  always_comb begin
    rs1_used = (dec.sel_a == SEL_REG);
    rs2_used = (dec.sel_b == SEL_REG) | dec.ctrl[CTRL_IS_ST_MEM] | dec.ctrl[CTRL_IS_BRANCH];
    hazard   = bus.in_valid_i & bus.ex_is_load_i & bus.fwd_valid_i[0] & (bus.fwd_rd_i[4:0] != 5'd0) &
               (((bus.fwd_rd_i[4:0] == rs1) & rs1_used) | ((bus.fwd_rd_i[4:0] == rs2) & rs2_used));
    adv      = bus.out_ready_i | ~valid_q;
  end

  assign bus.in_ready_o = bus.flush_i | (adv & ~hazard);

  // ID/EX next state: flush, bubble, load, drain, hold - in that priority
  always_comb begin
    id_ex_new.pc     = bus.pc_i;
    id_ex_new.funct3 = bus.instruction_i[14:12];
    id_ex_new.rd     = bus.instruction_i[11:7];
    id_ex_new.alu_op = dec.alu_op;
    id_ex_new.csr    = bus.instruction_i[31:20];
    id_ex_new.dat_a  = dat_a;
    id_ex_new.dat_b  = dat_b;
    id_ex_new.rs2    = rs2_dat;
    id_ex_new.imm    = imm;
    id_ex_new.ctrl   = dec.ctrl;
    id_ex_d = id_ex_q;
    valid_d = valid_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
    end else if (adv && hazard) begin
      valid_d = 1'b0;
    end else if (adv && bus.in_valid_i) begin
      valid_d = 1'b1;
      id_ex_d = id_ex_new;
    end else if (adv) begin
      valid_d = 1'b0;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      id_ex_q <= '0;
    end else begin
      valid_q <= valid_d;
      id_ex_q <= id_ex_d;
    end
  end

  assign bus.out_valid_o    = valid_q;
  assign bus.out_pc_o       = id_ex_q.pc;
  assign bus.out_funct3_o   = id_ex_q.funct3;
  assign bus.out_rd_o       = id_ex_q.rd;
  assign bus.out_alu_op_o   = id_ex_q.alu_op;
  assign bus.out_csr_addr_o = id_ex_q.csr;
  assign bus.out_dat_a_o    = id_ex_q.dat_a;
  assign bus.out_dat_b_o    = id_ex_q.dat_b;
  assign bus.out_rs2_dat_o  = id_ex_q.rs2;
  assign bus.out_imm_o      = id_ex_q.imm;
  assign bus.out_ctrl_o     = id_ex_q.ctrl;

`ifdef STAGE_ID_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

  // Saturating counters: bubble cycles and flushes that kill something
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (!bus.flush_i && adv && hazard && (perf_stall_q != 32'hFFFF_FFFF))
      perf_stall_d = perf_stall_q + 32'd1;
    if (bus.flush_i && (valid_q || bus.in_valid_i) && (perf_flush_q != 32'hFFFF_FFFF))
      perf_flush_d = perf_flush_q + 32'd1;
  end

  // Performance counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign bus.perf_stall_o = perf_stall_q;
  assign bus.perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_stage_id_pipe.sv
// tb/tb_stage_id_pipe.sv - scoreboard testbench for stage_id_pipe
module tb_stage_id_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_id_pipe_if #(.XLEN(32), .NUM_FWD(3)) bus ();
  stage_id_pipe #(.XLEN(32), .NUM_FWD(3)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [10:0] ctrl;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         e;
  logic [31:0]  rf_m [32];
  logic [175:0] act, expv;
  int           n_checks = 0;
  int           n_fail   = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid_i    = 1'b0;
    bus.instruction_i = 32'h0000_0013;
    bus.pc_i          = '0;
    bus.rd_i          = '0;
    bus.rf_wd_i       = '0;
    bus.rf_we_i       = 1'b0;
    bus.fwd_valid_i   = '0;
    bus.fwd_rd_i      = '0;
    bus.fwd_dat_i     = '0;
    bus.ex_is_load_i  = 1'b0;
    bus.flush_i       = 1'b0;
    bus.out_ready_i   = 1'b1;
  endtask

  task automatic set_fwd(input int k, input logic v, input logic [4:0] rd, input logic [31:0] dat);
    bus.fwd_valid_i[k]       = v;
    bus.fwd_rd_i[5*k +: 5]   = rd;
    bus.fwd_dat_i[32*k +: 32] = dat;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    bus.instruction_i = instr;
    bus.pc_i          = pc;
    bus.in_valid_i    = 1'b1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] rs2, input logic [31:0] imm, input logic [10:0] ctrl);
    exp_t t;
    t.pc = pc; t.rd = rd; t.a = a; t.b = b; t.rs2 = rs2; t.imm = imm; t.ctrl = ctrl;
    sb_q.push_back(t);
  endtask

  task automatic test_reset();
    logic [194:0] all_out;
    idle();
    rst = 1'b1;
    tick();
    tick();
    all_out = {bus.out_pc_o, bus.out_funct3_o, bus.out_rd_o, bus.out_alu_op_o, bus.out_csr_addr_o,
               bus.out_dat_a_o, bus.out_dat_b_o, bus.out_rs2_dat_o, bus.out_imm_o, bus.out_ctrl_o};
    n_checks++;
    if (bus.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: out_valid_o=%b, required 0", bus.out_valid_o);
    end
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_fields: outputs=%h, required 0", all_out);
    end
    rst = 1'b0;
    rf_m[0] = 32'd0;
    for (int k = 1; k < 32; k++) begin
      bus.rf_we_i = 1'b1;
      bus.rd_i    = 5'(k);
      bus.rf_wd_i = 32'h1000 + 32'(k);
      rf_m[k]     = 32'h1000 + 32'(k);
      tick();
    end
    idle();
    #1;
    n_checks++;
    if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: in_ready_o=%b out_valid_o=%b, required 1 and 0", bus.in_ready_o, bus.out_valid_o);
    end
  endtask

  task automatic test_addi();
    drive(32'h0050_0093, 32'h100);
    #1;
    n_checks++;
    if (bus.in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL addi_ready: in_ready_o=%b, required 1", bus.in_ready_o);
    end
    push(32'h100, 5'd1, 32'd0, 32'd5, rf_m[5], 32'd5, 11'h001);
    tick();
    idle();
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL addi_valid: out_valid_o=%b pending=%0d, required 1 with pending entry", bus.out_valid_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      act  = {bus.out_pc_o, bus.out_rd_o, bus.out_dat_a_o, bus.out_dat_b_o, bus.out_rs2_dat_o, bus.out_imm_o, bus.out_ctrl_o};
      expv = {e.pc, e.rd, e.a, e.b, e.rs2, e.imm, e.ctrl};
      if (act !== expv) begin
        n_fail++; $display("FAIL addi_fields: got %h, required %h", act, expv);
      end
    end
    tick();
  endtask

  task automatic test_fwd_priority();
    drive(32'h0020_81B3, 32'h104);
    set_fwd(0, 1'b1, 5'd1, 32'hAA);
    set_fwd(1, 1'b1, 5'd2, 32'h22);
    set_fwd(2, 1'b1, 5'd1, 32'h11);
    push(32'h104, 5'd3, 32'hAA, 32'h22, 32'h22, 32'd0, 11'h001);
    tick();
    idle();
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL fwd_valid: out_valid_o=%b pending=%0d, required 1 with pending entry", bus.out_valid_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      act  = {bus.out_pc_o, bus.out_rd_o, bus.out_dat_a_o, bus.out_dat_b_o, bus.out_rs2_dat_o, bus.out_imm_o, bus.out_ctrl_o};
      expv = {e.pc, e.rd, e.a, e.b, e.rs2, e.imm, e.ctrl};
      if (act !== expv) begin
        n_fail++; $display("FAIL fwd_fields: got %h, required %h", act, expv);
      end
    end
    tick();
  endtask

  task automatic test_load_use();
    drive(32'h0020_81B3, 32'h108);
    bus.ex_is_load_i = 1'b1;
    set_fwd(0, 1'b1, 5'd2, 32'h99);
    #1;
    n_checks++;
    if (bus.in_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL load_use_ready: in_ready_o=%b, required 0", bus.in_ready_o);
    end
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL load_use_bubble: out_valid_o=%b, required 0", bus.out_valid_o);
    end
    bus.ex_is_load_i = 1'b0;
    set_fwd(0, 1'b0, 5'd0, 32'd0);
    set_fwd(1, 1'b1, 5'd2, 32'h77);
    #1;
    n_checks++;
    if (bus.in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL load_use_release: in_ready_o=%b, required 1", bus.in_ready_o);
    end
    push(32'h108, 5'd3, rf_m[1], 32'h77, 32'h77, 32'd0, 11'h001);
    tick();
    idle();
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL load_use_valid: out_valid_o=%b pending=%0d, required 1 with pending entry", bus.out_valid_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      act  = {bus.out_pc_o, bus.out_rd_o, bus.out_dat_a_o, bus.out_dat_b_o, bus.out_rs2_dat_o, bus.out_imm_o, bus.out_ctrl_o};
      expv = {e.pc, e.rd, e.a, e.b, e.rs2, e.imm, e.ctrl};
      if (act !== expv) begin
        n_fail++; $display("FAIL load_use_fields: got %h, required %h", act, expv);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    drive(32'h0070_0113, 32'h200);
    push(32'h200, 5'd2, 32'd0, 32'd7, rf_m[7], 32'd7, 11'h001);
    tick();
    bus.out_ready_i = 1'b0;
    drive(32'h0090_0213, 32'h204);
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL bp_first_valid: out_valid_o=%b pending=%0d, required 1 with pending entry", bus.out_valid_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      act  = {bus.out_pc_o, bus.out_rd_o, bus.out_dat_a_o, bus.out_dat_b_o, bus.out_rs2_dat_o, bus.out_imm_o, bus.out_ctrl_o};
      expv = {e.pc, e.rd, e.a, e.b, e.rs2, e.imm, e.ctrl};
      if (act !== expv) begin
        n_fail++; $display("FAIL bp_first_fields: got %h, required %h", act, expv);
      end
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (bus.in_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready cycle %0d: in_ready_o=%b, required 0", c, bus.in_ready_o);
      end
      tick();
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_pc_o !== 32'h200 || bus.out_dat_b_o !== 32'd7) begin
        n_fail++; $display("FAIL bp_hold cycle %0d: valid=%b pc=%h dat_b=%h, required 1 00000200 00000007",
                           c, bus.out_valid_o, bus.out_pc_o, bus.out_dat_b_o);
      end
    end
    bus.out_ready_i = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: in_ready_o=%b, required 1", bus.in_ready_o);
    end
    push(32'h204, 5'd4, 32'd0, 32'd9, rf_m[9], 32'd9, 11'h001);
    tick();
    idle();
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL bp_second_valid: out_valid_o=%b pending=%0d, required 1 with pending entry", bus.out_valid_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      act  = {bus.out_pc_o, bus.out_rd_o, bus.out_dat_a_o, bus.out_dat_b_o, bus.out_rs2_dat_o, bus.out_imm_o, bus.out_ctrl_o};
      expv = {e.pc, e.rd, e.a, e.b, e.rs2, e.imm, e.ctrl};
      if (act !== expv) begin
        n_fail++; $display("FAIL bp_second_fields: got %h, required %h", act, expv);
      end
    end
    tick();
  endtask

  task automatic test_flush();
    drive(32'h0050_0093, 32'h300);
    push(32'h300, 5'd1, 32'd0, 32'd5, rf_m[5], 32'd5, 11'h001);
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL flush_pre_valid: out_valid_o=%b pending=%0d, required 1 with pending entry", bus.out_valid_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      act  = {bus.out_pc_o, bus.out_rd_o, bus.out_dat_a_o, bus.out_dat_b_o, bus.out_rs2_dat_o, bus.out_imm_o, bus.out_ctrl_o};
      expv = {e.pc, e.rd, e.a, e.b, e.rs2, e.imm, e.ctrl};
      if (act !== expv) begin
        n_fail++; $display("FAIL flush_pre_fields: got %h, required %h", act, expv);
      end
    end
    drive(32'h0090_0213, 32'h304);
    bus.out_ready_i = 1'b0;
    bus.flush_i     = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_ready: in_ready_o=%b, required 1", bus.in_ready_o);
    end
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (bus.out_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL flush_dropped cycle %0d: out_valid_o=%b pc=%h, required 0", c, bus.out_valid_o, bus.out_pc_o);
      end
      tick();
    end
  endtask

  task automatic test_write_through();
    drive(32'h0050_2023, 32'h400);
    bus.rf_we_i = 1'b1;
    bus.rd_i    = 5'd5;
    bus.rf_wd_i = 32'h1234;
    push(32'h400, 5'd0, 32'd0, 32'd0, 32'h1234, 32'd0, 11'h080);
    tick();
    rf_m[5] = 32'h1234;
    drive(32'h0050_2023, 32'h404);
    bus.rd_i    = 5'd0;
    bus.rf_wd_i = 32'hBEEF;
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL wt_valid: out_valid_o=%b pending=%0d, required 1 with pending entry", bus.out_valid_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      act  = {bus.out_pc_o, bus.out_rd_o, bus.out_dat_a_o, bus.out_dat_b_o, bus.out_rs2_dat_o, bus.out_imm_o, bus.out_ctrl_o};
      expv = {e.pc, e.rd, e.a, e.b, e.rs2, e.imm, e.ctrl};
      if (act !== expv) begin
        n_fail++; $display("FAIL wt_fields: got %h, required %h", act, expv);
      end
    end
    push(32'h404, 5'd0, 32'd0, 32'd0, rf_m[5], 32'd0, 11'h080);
    tick();
    idle();
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL wt_x0_valid: out_valid_o=%b pending=%0d, required 1 with pending entry", bus.out_valid_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      act  = {bus.out_pc_o, bus.out_rd_o, bus.out_dat_a_o, bus.out_dat_b_o, bus.out_rs2_dat_o, bus.out_imm_o, bus.out_ctrl_o};
      expv = {e.pc, e.rd, e.a, e.b, e.rs2, e.imm, e.ctrl};
      if (act !== expv) begin
        n_fail++; $display("FAIL wt_x0_fields: got %h, required %h", act, expv);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [3];
    instrs[0] = 32'hFFF0_0313;
    instrs[1] = 32'h1234_53B7;
    instrs[2] = 32'h0000_1417;
    for (int i = 0; i < 3; i++) begin
      idle();
      drive(instrs[i], 32'h500 + 32'(4 * i));
      case (i)
        0: begin
          set_fwd(0, 1'b1, 5'd0, 32'hFFFF);
          push(32'h500, 5'd6, 32'd0, 32'hFFFF_FFFF, rf_m[31], 32'hFFFF_FFFF, 11'h001);
        end
        1: begin
          bus.ex_is_load_i = 1'b1;
          set_fwd(0, 1'b1, 5'd8, 32'h5A5A);
          push(32'h504, 5'd7, 32'd0, 32'h1234_5000, rf_m[3], 32'h1234_5000, 11'h002);
        end
        default: begin
          push(32'h508, 5'd8, 32'h508, 32'h1000, 32'd0, 32'h1000, 11'h004);
        end
      endcase
      #1;
      n_checks++;
      if (bus.in_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready %0d: in_ready_o=%b, required 1", i, bus.in_ready_o);
      end
      tick();
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || sb_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_valid %0d: out_valid_o=%b pending=%0d, required 1 with pending entry", i, bus.out_valid_o, sb_q.size());
      end else begin
        e = sb_q.pop_front();
        act  = {bus.out_pc_o, bus.out_rd_o, bus.out_dat_a_o, bus.out_dat_b_o, bus.out_rs2_dat_o, bus.out_imm_o, bus.out_ctrl_o};
        expv = {e.pc, e.rd, e.a, e.b, e.rs2, e.imm, e.ctrl};
        if (act !== expv) begin
          n_fail++; $display("FAIL b2b_fields %0d: got %h, required %h", i, act, expv);
        end
      end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive(32'h0050_0093, 32'h600);
    tick();
    bus.out_ready_i = 1'b0;
    drive(32'h0090_0213, 32'h604);
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_pc_o !== 32'h600) begin
      n_fail++; $display("FAIL stall_held: valid=%b pc=%h, required 1 00000600", bus.out_valid_o, bus.out_pc_o);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b0 || bus.out_pc_o !== 32'd0) begin
      n_fail++; $display("FAIL stall_reset: valid=%b pc=%h, required 0 00000000", bus.out_valid_o, bus.out_pc_o);
    end
    rst = 1'b0;
    idle();
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_discard: out_valid_o=%b, required 0", bus.out_valid_o);
    end
    drive(32'h0050_2023, 32'h700);
    push(32'h700, 5'd0, 32'd0, 32'd0, rf_m[5], 32'd0, 11'h080);
    tick();
    idle();
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL rf_kept_valid: out_valid_o=%b pending=%0d, required 1 with pending entry", bus.out_valid_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      act  = {bus.out_pc_o, bus.out_rd_o, bus.out_dat_a_o, bus.out_dat_b_o, bus.out_rs2_dat_o, bus.out_imm_o, bus.out_ctrl_o};
      expv = {e.pc, e.rd, e.a, e.b, e.rs2, e.imm, e.ctrl};
      if (act !== expv) begin
        n_fail++; $display("FAIL rf_kept_fields: got %h, required %h", act, expv);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_fwd_priority();
    test_load_use();
    test_backpressure();
    test_flush();
    test_write_through();
    test_back_to_back();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
